// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle-ROM sequencer for the R16 FFT: stage-0 table load bursts, then per-stage ROM read sweeps.
// Defining TW_SEQ_PERF_EN adds the stall_cycles back-pressure counter output.
module tw_rom_seq_ctrl #(
    parameter int SC_WIDTH      = 3,
    parameter int S_WIDTH       = 4,
    parameter int horizontal_DW = 64,
    parameter int LOAD_WORDS    = 4,
    parameter int STAGE_NUM     = 3,
    parameter int STAGE_LEN     = 256,
    parameter int CNT_WIDTH     = 9,
    parameter int GAP           = 2
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     load_en,
    input  logic                     row_valid,
    input  logic [horizontal_DW-1:0] row_data,
    output logic                     row_ready,
    input  logic                     stall,
    output logic [SC_WIDTH-1:0]      stage_counter,
    output logic                     CEN,
    output logic [S_WIDTH-1:0]       state,
    output logic [1:0]               ROM1_w,
    output logic [horizontal_DW-1:0] horizontal_row0_out,
    output logic [CNT_WIDTH-1:0]     rd_cnt,
    output logic                     busy,
    output logic                     done
`ifdef TW_SEQ_PERF_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    // state    | meaning
    // IDLE     | wait for start          COLLECT  | fill hi/lo row buffer from host
    // BURST_HI | write hi rows, ROM1_w=1 BURST_LO | write lo rows, ROM1_w=2
    // RUN      | read sweep, more stages DRAIN    | CEN-high gap between stages
    // RUN_LAST | final read sweep        DONE     | one-cycle done pulse

    localparam int BUF_WORDS = 2 * LOAD_WORDS;
    localparam int IDX_W     = $clog2(BUF_WORDS);
    localparam int GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_WIDTH-1:0] LEN_TC      = CNT_WIDTH'(STAGE_LEN);
    localparam logic [SC_WIDTH-1:0]  LAST_STAGE  = SC_WIDTH'(STAGE_NUM - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(BUF_WORDS - 1);
    localparam logic [IDX_W-1:0]     IDX_HI_LAST = IDX_W'(LOAD_WORDS - 1);
    localparam logic [GAP_W-1:0]     GAP_INIT    = GAP_W'(GAP - 1);

    typedef enum logic [S_WIDTH-1:0] {
        ST_IDLE     = S_WIDTH'(0),
        ST_COLLECT  = S_WIDTH'(1),
        ST_BURST_HI = S_WIDTH'(2),
        ST_BURST_LO = S_WIDTH'(3),
        ST_RUN      = S_WIDTH'(4),
        ST_DRAIN    = S_WIDTH'(5),
        ST_RUN_LAST = S_WIDTH'(6),
        ST_DONE     = S_WIDTH'(7)
    } st_t;

    st_t                     st;
    logic [IDX_W-1:0]        idx;
    logic [GAP_W-1:0]        gap_cnt;
    logic [SC_WIDTH-1:0]     sc_next;
    logic [horizontal_DW-1:0] row_buf [BUF_WORDS];

    assign state   = st;
    assign sc_next = stage_counter + SC_WIDTH'(1);

    // Buffer contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge CLK) begin
        if (st == ST_COLLECT && row_valid && row_ready)
            row_buf[idx] <= row_data;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            st                  <= ST_IDLE;
            idx                 <= '0;
            gap_cnt             <= '0;
            stage_counter       <= '0;
            CEN                 <= 1'b1;
            ROM1_w              <= 2'd0;
            horizontal_row0_out <= '0;
            rd_cnt              <= '0;
            row_ready           <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        idx           <= '0;
                        stage_counter <= '0;
                        if (load_en) begin
                            st        <= ST_COLLECT;
                            row_ready <= 1'b1;
                            rd_cnt    <= '0;
                        end else begin
                            st     <= ST_RUN;
                            CEN    <= stall;
                            rd_cnt <= CNT_WIDTH'(!stall);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (row_valid && row_ready) begin
                        if (idx == IDX_LAST) begin
                            row_ready           <= 1'b0;
                            st                  <= ST_BURST_HI;
                            idx                 <= '0;
                            ROM1_w              <= 2'd1;
                            horizontal_row0_out <= row_buf[0];
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                // The two bursts run back to back so the ROM's row index never slips.
                ST_BURST_HI, ST_BURST_LO: begin
                    if (idx == IDX_LAST) begin
                        ROM1_w              <= 2'd0;
                        horizontal_row0_out <= '0;
                        idx                 <= '0;
                        stage_counter       <= '0;
                        st                  <= ST_RUN;
                        CEN                 <= stall;
                        rd_cnt              <= CNT_WIDTH'(!stall);
                    end else begin
                        idx                 <= idx + IDX_W'(1);
                        horizontal_row0_out <= row_buf[idx + IDX_W'(1)];
                        if (idx == IDX_HI_LAST) begin
                            st     <= ST_BURST_LO;
                            ROM1_w <= 2'd2;
                        end
                    end
                end
                ST_RUN, ST_RUN_LAST: begin
                    if (rd_cnt == LEN_TC) begin
                        CEN    <= 1'b1;
                        rd_cnt <= '0;
                        if (st == ST_RUN) begin
                            st      <= ST_DRAIN;
                            gap_cnt <= GAP_INIT;
                        end else begin
                            st   <= ST_DONE;
                            done <= 1'b1;
                        end
                    end else if (stall) begin
                        CEN <= 1'b1;
                    end else begin
                        CEN    <= 1'b0;
                        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (gap_cnt == '0) begin
                        stage_counter <= sc_next;
                        st            <= (sc_next == LAST_STAGE) ? ST_RUN_LAST : ST_RUN;
                        CEN           <= stall;
                        rd_cnt        <= CNT_WIDTH'(!stall);
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    busy          <= 1'b0;
                    stage_counter <= '0;
                    st            <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

`ifdef TW_SEQ_PERF_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (st == ST_IDLE && start)
            stall_cycles <= '0;
        else if ((st == ST_RUN || st == ST_RUN_LAST) && stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Bench for tw_rom_seq_ctrl: table load/burst ordering, mid-burst reset, and stage sweeps under stall.
module tb_tw_rom_seq_ctrl;
    localparam int DW   = 64;
    localparam int LW   = 4;
    localparam int SN   = 3;
    localparam int SL   = 256;
    localparam int GP   = 2;
    localparam int MAXC = 2000;

    logic          CLK = 1'b0;
    logic          rst, start, load_en, row_valid, stall;
    logic [DW-1:0] row_data;
    logic          row_ready;
    logic [2:0]    stage_counter;
    logic          CEN;
    logic [3:0]    state;
    logic [1:0]    ROM1_w;
    logic [DW-1:0] horizontal_row0_out;
    logic [8:0]    rd_cnt;
    logic          busy, done;
`ifdef TW_SEQ_PERF_EN
    logic [15:0]   stall_cycles;
    int            e_stalls;
`endif

    int checks = 0;
    int errors = 0;

    bit stl     [MAXC];
    int e_state [MAXC];
    int e_cen   [MAXC];
    int e_sc    [MAXC];
    int e_rd    [MAXC];
    int e_busy  [MAXC];
    int e_done  [MAXC];
    int e_b     [SN];
    int run_len;

    tw_rom_seq_ctrl dut (
        .CLK(CLK), .rst(rst), .start(start), .load_en(load_en),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .stall(stall), .stage_counter(stage_counter), .CEN(CEN), .state(state),
        .ROM1_w(ROM1_w), .horizontal_row0_out(horizontal_row0_out),
        .rd_cnt(rd_cnt), .busy(busy), .done(done)
`ifdef TW_SEQ_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected trace indexed by the clock edge counted from the edge that enters the first stage.
    // A stage ends on its SL-th un-stalled sample; the next sample is ignored, then GP drain
    // cycles follow and the sample at the drain's last edge opens the next stage.
    function automatic void build_expect();
        int a = 0;
        int j;
        int b;
        int zeros;
`ifdef TW_SEQ_PERF_EN
        e_stalls = 0;
`endif
        for (int s = 0; s < SN; s++) begin
            zeros = 0;
            j = a;
            while (zeros < SL && j < MAXC - GP - 3) begin
                if (!stl[j]) zeros++;
                e_state[j] = (s == SN - 1) ? 6 : 4;
                e_cen[j]   = int'(stl[j]);
                e_sc[j]    = s;
                e_rd[j]    = zeros;
                e_busy[j]  = 1;
                e_done[j]  = 0;
`ifdef TW_SEQ_PERF_EN
                if (j > a && stl[j]) e_stalls++;
`endif
                j++;
            end
            b = j - 1;
            e_b[s] = b;
`ifdef TW_SEQ_PERF_EN
            if (stl[b + 1]) e_stalls++;
`endif
            if (s < SN - 1) begin
                for (int g = 1; g <= GP; g++) begin
                    e_state[b + g] = 5; e_cen[b + g] = 1; e_sc[b + g] = s;
                    e_rd[b + g] = 0; e_busy[b + g] = 1; e_done[b + g] = 0;
                end
                a = b + GP + 1;
            end else begin
                e_state[b + 1] = 7; e_cen[b + 1] = 1; e_sc[b + 1] = -1;
                e_rd[b + 1] = -1; e_busy[b + 1] = 1; e_done[b + 1] = 1;
                e_state[b + 2] = 0; e_cen[b + 2] = 1; e_sc[b + 2] = 0;
                e_rd[b + 2] = -1; e_busy[b + 2] = 0; e_done[b + 2] = 0;
                run_len = b + 3;
            end
        end
    endfunction

    task automatic do_load(input bit rnd, input int rst_at);
        logic [DW-1:0] q [$];
        logic [DW-1:0] d;
        int gap;
        start = 1'b1; load_en = 1'b1;
        tick();
        start = 1'b0; load_en = 1'b0;
        chk("collect_state", state, 1);
        chk("collect_ready", row_ready, 1);
        chk("collect_busy", busy, 1);
        for (int n = 0; n < 2 * LW; n++) begin
            d = rnd ? {$urandom, $urandom} : DW'(n + 1);
            q.push_back(d);
            row_valid = 1'b1; row_data = d;
            tick();
            row_valid = 1'b0; row_data = {$urandom, $urandom};
            if (n < 2 * LW - 1) begin
                chk("collect_hold_state", state, 1);
                gap = rnd ? int'($urandom_range(0, 2)) : 1;
                repeat (gap) begin
                    tick();
                    chk("collect_gap_ready", row_ready, 1);
                end
            end
        end
        for (int k = 0; k < 2 * LW; k++) begin
            chk("burst_sel", ROM1_w, (k < LW) ? 1 : 2);
            chk("burst_data", horizontal_row0_out, q[k]);
            chk("burst_state", state, (k < LW) ? 2 : 3);
            chk("burst_ready", row_ready, 0);
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge CLK);
                #1;
                chk("rst_rom1_w", ROM1_w, 0);
                chk("rst_cen", CEN, 1);
                chk("rst_state", state, 0);
                chk("rst_busy", busy, 0);
                rst = 1'b0;
                return;
            end
            if (k < 2 * LW - 1) tick();
        end
    endtask

    task automatic run_trace(input int spur, output int busy_n);
        int reads = 0;
        int dones = 0;
        busy_n = 0;
        for (int i = 0; i < run_len; i++) begin
            stall = stl[i];
            if (i == spur) begin start = 1'b1; load_en = 1'b1; end
            tick();
            start = 1'b0; load_en = 1'b0;
            chk("run_state", state, e_state[i]);
            chk("run_cen", CEN, e_cen[i]);
            chk("run_busy", busy, e_busy[i]);
            chk("run_done", done, e_done[i]);
            if (e_sc[i] >= 0) chk("run_stage", stage_counter, e_sc[i]);
            if (e_rd[i] >= 0) chk("run_rd_cnt", rd_cnt, e_rd[i]);
            if (!CEN) reads++;
            if (done) dones++;
            if (busy) busy_n++;
        end
        stall = 1'b0;
        chk("total_reads", reads, SN * SL);
        chk("done_pulses", dones, 1);
`ifdef TW_SEQ_PERF_EN
        chk("stall_cycles", stall_cycles, e_stalls);
`endif
    endtask

    initial begin
        int busy_n;
        rst = 1'b1; start = 1'b0; load_en = 1'b0;
        row_valid = 1'b0; row_data = '0; stall = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_cen", CEN, 1);
        chk("reset_stage", stage_counter, 0);
        chk("reset_state", state, 0);
        chk("reset_rom1_w", ROM1_w, 0);
        chk("reset_row_out", horizontal_row0_out, 0);
        chk("reset_rd_cnt", rd_cnt, 0);
        chk("reset_ready", row_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", state, 0);

        // Load aborted by reset on the third high-half write.
        do_load(1'b1, 2);
        repeat (2) tick();
        chk("abort_idle_state", state, 0);
        chk("abort_idle_w", ROM1_w, 0);

        // Load 1..8 with one-cycle gaps, then stages with directed stalls and a stray start.
        for (int i = 0; i < MAXC; i++) stl[i] = 1'b0;
        for (int i = 300; i < 310; i++) stl[i] = 1'b1;
        build_expect();
        stl[e_b[0] + 1]      = 1'b1;
        stl[e_b[SN - 1] + 1] = 1'b1;
        build_expect();
        do_load(1'b0, -1);
        run_trace(400, busy_n);

        // No load, no stall: fixed activity length.
        for (int i = 0; i < MAXC; i++) stl[i] = 1'b0;
        build_expect();
        start = 1'b1; load_en = 1'b0;
        run_trace(-1, busy_n);
        chk("active_cycles", busy_n, SN * SL + (SN - 1) * GP + 1);

        // Random stall patterns, one through the load path and one direct.
        for (int r = 0; r < 2; r++) begin
            int burst_at;
            for (int i = 0; i < MAXC; i++) stl[i] = ($urandom_range(0, 7) == 0);
            burst_at = int'($urandom_range(100, 700));
            for (int i = 0; i < 12; i++) stl[burst_at + i] = 1'b1;
            build_expect();
            if (r == 0) begin
                do_load(1'b1, -1);
            end else begin
                start = 1'b1; load_en = 1'b0;
            end
            run_trace(int'($urandom_range(50, 600)), busy_n);
        end

        tick();
        chk("final_idle", state, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
